// File: rtl/pio_in_edge_irq.sv
// -----------------------------------------------------------------------------
// pio_in_edge_irq
// Avalon-MM input PIO for push-buttons and switches. Each input bit is
// synchronised and optionally debounced. Edges on the filtered value are
// latched into sticky per-bit flags, and a maskable level IRQ is raised.
//
// Register map (word address):
//   0 data (filtered input, read only)
//   1 reads 0
//   2 irqmask
//   3 edgecapture (write 1 to clear a bit)
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   address, chipselect,   Avalon slave write/read interface; readdata is
//   write_n, writedata,    registered every clock (1-cycle read latency)
//   readdata
//   in_port [WIDTH]        asynchronous external inputs
//   irq                    level interrupt, |(edgecapture & irqmask) registered
// -----------------------------------------------------------------------------
module pio_in_edge_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Counter is kept one bit wide when filtering is disabled so the
  // declarations stay legal; it is held at zero in that case.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            filt_q, filt_d;
  logic [WIDTH-1:0]            filt_dly_q, filt_dly_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            irqmask_q, irqmask_d;
  logic [WIDTH-1:0]            edgecap_q, edgecap_d;
  logic [31:0]                 readdata_q, readdata_d;
  logic                        irq_q, irq_d;

  logic [WIDTH-1:0] rise, fall, edge_set, clr_mask, rd_val;
  logic             wr_en;
  logic             unused_writedata;

  // Only the low WIDTH bits of writedata carry information.
  assign unused_writedata = ^writedata;

  // Two-flop synchroniser, then delayed copy of the filtered value for edges.
  always_comb begin
    sync1_d    = in_port;
    sync2_d    = sync1_q;
    filt_dly_d = filt_q;
  end

  // Debounce: a change must be seen on D consecutive clocks before it is
  // accepted; any return to the filtered value restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (DEBOUNCE_CYCLES == 0) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge detection, sticky capture and register writes.
  always_comb begin
    rise  = filt_q & ~filt_dly_q;
    fall  = ~filt_q & filt_dly_q;
    wr_en = chipselect & ~write_n;
    case (EDGE_TYPE)
      0:       edge_set = rise;
      1:       edge_set = fall;
      default: edge_set = rise | fall;
    endcase
    clr_mask  = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // A new edge in the same clock as a clear keeps the flag set.
    edgecap_d = (edgecap_q & ~clr_mask) | edge_set;
    irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  // Read mux, registered unconditionally; reads have no side effects.
  always_comb begin
    case (address)
      2'd0:    rd_val = filt_q;
      2'd2:    rd_val = irqmask_q;
      2'd3:    rd_val = edgecap_q;
      default: rd_val = '0;
    endcase
    readdata_d             = '0;
    readdata_d[WIDTH-1:0]  = rd_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      cnt_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      cnt_q      <= cnt_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs_a, cs_b, cs_c;
  logic [3:0]  in_a, in_b;
  logic [31:0] in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  always #5 clk = ~clk;

  // A: 4 bits, no filter, rising edges
  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .irq(irq_a));

  // B: 4 bits, 4-clock filter, any edge
  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .irq(irq_b));

  // C: 32 bits, no filter, rising edges
  pio_in_edge_irq #(.WIDTH(32), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_c),
    .write_n(write_n), .writedata(writedata), .readdata(rd_c),
    .in_port(in_c), .irq(irq_c));

  typedef struct {
    int          dut;
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic req    = 1'b0;
  logic req_q  = 1'b0;

  always @(posedge clk) req_q <= req;

  // Monitor: each request produces one observation one edge later.
  chk_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    if (req_q) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: observation with no expected entry");
      end else begin
        m_e = sb.pop_front();
        case (m_e.dut)
          0:       m_act = m_e.is_irq ? {31'b0, irq_a} : rd_a;
          1:       m_act = m_e.is_irq ? {31'b0, irq_b} : rd_b;
          default: m_act = m_e.is_irq ? {31'b0, irq_c} : rd_c;
        endcase
        n_chk++;
        if (m_act === m_e.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", m_e.name, m_act, m_e.exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input int dut, input logic [1:0] a, input logic [31:0] exp,
                    input string nm);
    chk_t c;
    address = a;
    write_n = 1'b1;
    req     = 1'b1;
    c.dut = dut; c.is_irq = 1'b0; c.exp = exp; c.name = nm;
    sb.push_back(c);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic chk_irq(input int dut, input logic exp, input string nm);
    chk_t c;
    req = 1'b1;
    c.dut = dut; c.is_irq = 1'b1; c.exp = {31'b0, exp}; c.name = nm;
    sb.push_back(c);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wr(input int dut, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a = (dut == 0); cs_b = (dut == 1); cs_c = (dut == 2);
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
    write_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; address = 2'd0; write_n = 1'b1; writedata = '0;
    cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    idle(3);
    reset_n = 1'b1;

    // Reset state
    rd(0, 2'd0, 32'h0, "rst_a_data");
    rd(0, 2'd1, 32'h0, "rst_a_addr1");
    rd(0, 2'd2, 32'h0, "rst_a_mask");
    rd(0, 2'd3, 32'h0, "rst_a_edge");
    chk_irq(0, 1'b0, "rst_a_irq");
    rd(1, 2'd3, 32'h0, "rst_b_edge");
    rd(2, 2'd0, 32'h0, "rst_c_data");

    // Unfiltered latency: value visible on the fourth read
    in_a = 4'hA;
    rd(0, 2'd0, 32'h0, "lat_a_0");
    rd(0, 2'd0, 32'h0, "lat_a_1");
    rd(0, 2'd0, 32'h0, "lat_a_2");
    rd(0, 2'd0, 32'hA, "lat_a_3");
    idle(2);
    rd(0, 2'd3, 32'hA, "a_rise_cap");
    chk_irq(0, 1'b0, "a_masked_irq");

    // Rising-only capture, mask, clear
    wr(0, 2'd3, 32'hF);
    rd(0, 2'd3, 32'h0, "a_clear_all");
    wr(0, 2'd2, 32'h1);
    rd(0, 2'd2, 32'h1, "a_mask_rd");
    in_a = 4'hB;
    idle(6);
    rd(0, 2'd3, 32'h1, "a_bit0_rise");
    chk_irq(0, 1'b1, "a_irq_set");
    in_a = 4'hA;
    idle(6);
    rd(0, 2'd3, 32'h1, "a_fall_ignored");
    wr(0, 2'd3, 32'h1);
    rd(0, 2'd3, 32'h0, "a_w1c");
    chk_irq(0, 1'b0, "a_irq_clr");

    // Debounce: 3-clock glitch rejected
    in_b = 4'h1;
    idle(3);
    in_b = 4'h0;
    idle(8);
    rd(1, 2'd0, 32'h0, "b_glitch_data");
    rd(1, 2'd3, 32'h0, "b_glitch_edge");

    // Debounce: held input accepted after 4 stable clocks
    in_b = 4'h1;
    for (int i = 0; i < 6; i++) rd(1, 2'd0, 32'h0, "b_deb_wait");
    rd(1, 2'd0, 32'h1, "b_deb_pass");
    rd(1, 2'd3, 32'h1, "b_deb_cap");

    // Set wins over a same-clock clear
    wr(1, 2'd2, 32'h3);
    in_b = 4'h3;
    idle(10);
    rd(1, 2'd3, 32'h3, "b_both_set");
    chk_irq(1, 1'b1, "b_irq_on");
    in_b = 4'h1;
    idle(6);
    wr(1, 2'd3, 32'h2);
    rd(1, 2'd3, 32'h3, "b_set_wins");
    chk_irq(1, 1'b1, "b_irq_stays");
    wr(1, 2'd3, 32'h1);
    rd(1, 2'd3, 32'h2, "b_clr_bit0");
    wr(1, 2'd3, 32'h2);
    rd(1, 2'd3, 32'h0, "b_clr_bit1");
    idle(1);
    chk_irq(1, 1'b0, "b_irq_off");

    // Reset mid-debounce with mask and flags set
    wr(1, 2'd2, 32'hF);
    in_b = 4'h2;
    idle(8);
    rd(1, 2'd3, 32'h3, "b_pre_rst_edge");
    chk_irq(1, 1'b1, "b_pre_rst_irq");
    in_b = 4'hC;
    idle(2);
    reset_n = 1'b0;
    rd(1, 2'd2, 32'h0, "b_in_rst_mask");
    reset_n = 1'b1;
    rd(1, 2'd0, 32'h0, "b_post_data");
    rd(1, 2'd1, 32'h0, "b_post_addr1");
    rd(1, 2'd2, 32'h0, "b_post_mask");
    rd(1, 2'd3, 32'h0, "b_post_edge");
    chk_irq(1, 1'b0, "b_post_irq");

    // Input held high out of reset: one rising capture, no irq
    idle(8);
    rd(0, 2'd0, 32'hA, "a_post_data");
    rd(0, 2'd3, 32'hA, "a_post_cap");
    chk_irq(0, 1'b0, "a_post_irq");
    wr(0, 2'd2, 32'hFFFF_FFFF);
    rd(0, 2'd2, 32'h0000_000F, "a_mask_upper0");
    idle(1);
    chk_irq(0, 1'b1, "a_unmask_irq");

    // Full-width instance
    in_c = 32'hFFFF_FFFF;
    idle(4);
    rd(2, 2'd0, 32'hFFFF_FFFF, "c_data");
    wr(2, 2'd2, 32'hFFFF_FFFF);
    rd(2, 2'd2, 32'hFFFF_FFFF, "c_mask");
    rd(2, 2'd3, 32'hFFFF_FFFF, "c_edge");
    rd(2, 2'd1, 32'h0, "c_addr1");
    chk_irq(2, 1'b1, "c_irq");

    // Drain the scoreboard within a bounded number of clocks
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk += sb.size();
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
